// File: rtl/gcd_binary_stream.sv
// rtl/gcd_binary_stream.sv - parametrised binary (Stein) GCD engine with valid/ready handshakes
// Optional REDUCE cycle counter on the cycles port: define GCD_CYCLE_COUNT_EN.
module gcd_binary_stream #(
  parameter int WIDTH = 40,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
`ifdef GCD_CYCLE_COUNT_EN
  ,
  output logic [CNT_W-1:0] cycles
`endif
);

  localparam int KW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REDUCE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] result_q, result_d;

  // Handshake flags decode straight from the state register.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;

  // Next-state logic: accept/zero handling in IDLE, one Stein step per REDUCE cycle.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    k_d      = k_q;
    result_d = result_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x_d = a;
          y_d = b;
          k_d = '0;
          if (a == '0) begin
            result_d = b;
            state_d  = ST_DONE;
          end else if (b == '0) begin
            result_d = a;
            state_d  = ST_DONE;
          end else begin
            state_d = ST_REDUCE;
          end
        end
      end
      ST_REDUCE: begin
        if (x_q == y_q) begin
          // Common power of two is reapplied only once, on the way out.
          result_d = x_q << k_q;
          state_d  = ST_DONE;
        end else if (!x_q[0] && !y_q[0]) begin
          x_d = x_q >> 1;
          y_d = y_q >> 1;
          k_d = k_q + 1'b1;
        end else if (!x_q[0]) begin
          x_d = x_q >> 1;
        end else if (!y_q[0]) begin
          y_d = y_q >> 1;
        end else if (x_q > y_q) begin
          // Both odd here, so the difference is even and the shift drops no bits.
          x_d = (x_q - y_q) >> 1;
        end else begin
          y_d = (y_q - x_q) >> 1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef GCD_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cycles_q, cycles_d;

  assign cycles = cycles_q;

  // Saturating count of REDUCE cycles, cleared when a new pair is accepted.
  always_comb begin
    cycles_d = cycles_q;
    if (state_q == ST_IDLE && in_valid) begin
      cycles_d = '0;
    end else if (state_q == ST_REDUCE && cycles_q != {CNT_W{1'b1}}) begin
      cycles_d = cycles_q + 1'b1;
    end
  end

  // Counter register; reset discards any partial count.
  always_ff @(posedge clk) begin
    if (reset) cycles_q <= '0;
    else       cycles_q <= cycles_d;
  end
`endif

  // State register for the FSM and datapath; reset aborts any computation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      k_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      k_q      <= k_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_gcd_binary_stream.sv
// tb/tb_gcd_binary_stream.sv - randomized self-checking bench for gcd_binary_stream
module tb_gcd_binary_stream;

  localparam int W     = 40;
  localparam int CW    = 4;
  localparam int LIMIT = 2 * W + 1;
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic [CW-1:0] cycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gcd_binary_stream #(.WIDTH(W), .CNT_W(CW)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
`ifdef GCD_CYCLE_COUNT_EN
    ,
    .cycles    (cycles)
`endif
  );

`ifndef GCD_CYCLE_COUNT_EN
  assign cycles = '0;
`endif

  // Reference gcd by Euclid's remainder algorithm.
  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] p, input logic [W-1:0] q);
    logic [W-1:0] u, v, t;
    u = p;
    v = q;
    while (v != '0) begin
      t = u % v;
      u = v;
      v = t;
    end
    return u;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return {{(W-1){1'b0}}, 1'b1};
      2:       return {W{1'b1}};
      3:       return W'($urandom_range(0, 255));
      4:       return W'(r[W-1:0] << $urandom_range(0, 30));
      default: return r[W-1:0];
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pair, then wait (bounded) for out_valid; lat = REDUCE edges observed.
  task automatic do_op(input logic [W-1:0] pa, input logic [W-1:0] pb,
                       output logic [W-1:0] res, output int lat);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL op_in_ready a=%0d b=%0d: in_ready=%b required 1", pa, pb, in_ready);
    end
    a = pa;
    b = pb;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat <= LIMIT + 4) begin
      tick();
      lat++;
    end
    res = result;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL op_timeout a=%0d b=%0d: no out_valid after %0d cycles, required within %0d",
               pa, pb, lat, LIMIT);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b result=%0d required 1 0 0",
               in_ready, out_valid, result);
    end
`ifdef GCD_CYCLE_COUNT_EN
    checks++;
    if (cycles !== '0) begin
      errors++;
      $display("FAIL reset_cycles: cycles=%0d required 0", cycles);
    end
`endif
  endtask

  task automatic test_basic();
    logic [W-1:0] res;
    int lat;
    out_ready = 1'b1;
    do_op(W'(48), W'(18), res, lat);
    checks++;
    if (res !== W'(6) || lat != 6) begin
      errors++;
      $display("FAIL basic_48_18: result=%0d reduce=%0d required 6 and 6", res, lat);
    end
`ifdef GCD_CYCLE_COUNT_EN
    checks++;
    if (cycles !== CW'(6)) begin
      errors++;
      $display("FAIL basic_cycles: cycles=%0d required 6", cycles);
    end
`endif
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_zero();
    logic [W-1:0] res;
    int lat;
    logic [W-1:0] za [4] = '{W'(0), W'(0), W'(35), W'(35)};
    logic [W-1:0] zb [4] = '{W'(35), W'(0), W'(0), W'(35)};
    logic [W-1:0] zr [4] = '{W'(35), W'(0), W'(35), W'(35)};
    int           zl [4] = '{0, 0, 0, 1};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_op(za[i], zb[i], res, lat);
      checks++;
      if (res !== zr[i] || lat != zl[i]) begin
        errors++;
        $display("FAIL zero_case a=%0d b=%0d: result=%0d reduce=%0d required %0d and %0d",
                 za[i], zb[i], res, lat, zr[i], zl[i]);
      end
`ifdef GCD_CYCLE_COUNT_EN
      checks++;
      if (cycles !== CW'(zl[i])) begin
        errors++;
        $display("FAIL zero_cycles a=%0d b=%0d: cycles=%0d required %0d", za[i], zb[i], cycles, zl[i]);
      end
`endif
      tick();
    end
  endtask

  task automatic test_pow2();
    logic [W-1:0] res;
    logic [W-1:0] pa;
    logic [W-1:0] pb;
    int lat;
    pa = W'(1) << 39;
    pb = W'(1) << 20;
    out_ready = 1'b1;
    do_op(pa, pb, res, lat);
    checks++;
    if (res !== W'(40'h0000100000)) begin
      errors++;
      $display("FAIL pow2_result: result=%h required 0000100000", res);
    end
`ifdef GCD_CYCLE_COUNT_EN
    checks++;
    if (cycles !== CMAX) begin
      errors++;
      $display("FAIL pow2_cycles_saturate: cycles=%0d required %0d", cycles, CMAX);
    end
`endif
    tick();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] res;
    int lat;
    out_ready = 1'b0;
    do_op(W'(48), W'(18), res, lat);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        a = W'(9);
        b = W'(6);
        in_valid = 1'b1;
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (result !== W'(6) || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold cycle %0d: result=%0d out_valid=%b in_ready=%b required 6 1 0",
                 i, result, out_valid, in_ready);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== W'(6)) begin
      errors++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b result=%0d required 1 0 6",
               in_ready, out_valid, result);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_no_queue: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_reset_midop();
    logic [W-1:0] res;
    int lat;
    out_ready = 1'b1;
    a = W'(1071);
    b = W'(462);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || cycles !== '0) begin
      errors++;
      $display("FAIL midop_reset: in_ready=%b out_valid=%b result=%0d cycles=%0d required 1 0 0 0",
               in_ready, out_valid, result, cycles);
    end
    do_op(W'(1071), W'(462), res, lat);
    checks++;
    if (res !== W'(21)) begin
      errors++;
      $display("FAIL midop_rerun: result=%0d required 21", res);
    end
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] pa, pb, res, exp;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 500; i++) begin
      pa = rnd_op();
      pb = ($urandom_range(0, 9) == 0) ? pa : rnd_op();
      exp = ref_gcd(pa, pb);
      do_op(pa, pb, res, lat);
      checks++;
      if (res !== exp || lat > LIMIT) begin
        errors++;
        $display("FAIL random a=%h b=%h: result=%h reduce=%0d required %h within %0d",
                 pa, pb, res, lat, exp, LIMIT);
      end
`ifdef GCD_CYCLE_COUNT_EN
      checks++;
      if (cycles !== ((lat >= int'(CMAX)) ? CMAX : CW'(lat))) begin
        errors++;
        $display("FAIL random_cycles a=%h b=%h: cycles=%0d reduce=%0d", pa, pb, cycles, lat);
      end
`endif
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_pow2();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
